// File: rtl/calc_pkg.sv
// calc_pkg: shared operation/state encodings, widths and the BCD digit adjust helper
package calc_pkg;
    localparam int DATA_W = 14;
    localparam int BCD_W  = 16;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_CONV, S_DONE} state_t;
    function automatic logic [3:0] bcd_adj(input logic [3:0] d);
        return d > 4'd4 ? d + 4'd3 : d;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble; the load edge performs the first of 14 shifts
// so the remaining 13 complete while the caller waits in its conversion state.
module bin2bcd_seq
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] bin,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);
    logic [DATA_W-1:0] r_bin;
    logic [BCD_W-1:0]  r_bcd;
    logic [3:0]        r_cnt;
    logic [BCD_W-1:0]  w_adj;

    always_comb begin
        w_adj = {bcd_adj(r_bcd[15:12]), bcd_adj(r_bcd[11:8]), bcd_adj(r_bcd[7:4]), bcd_adj(r_bcd[3:0])};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_bin <= {bin[DATA_W-2:0], 1'b0};
            r_bcd <= BCD_W'(bin[DATA_W-1]);
            r_cnt <= 4'(DATA_W - 1);
        end else if (r_cnt != 4'd0) begin
            {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign done = r_cnt == 4'd0;
    assign bcd  = r_bcd;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: two-digit BCD add/sub/mul/div sequencer with BCD result.
// Divider present only when CALC_SEQ_DIV_EN is defined; otherwise op=11 reports err.
module calc_sequencer
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       a_tens,
    input  logic [3:0]       a_ones,
    input  logic [3:0]       b_tens,
    input  logic [3:0]       b_ones,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] result_bcd,
    output logic             neg,
    output logic             err
);
    state_t            r_state, w_next;
    op_t               r_op;
    logic [3:0]        r_at, r_ao, r_bt, r_bo;
    logic [6:0]        r_a, r_b;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_acc;
    logic              r_neg_nx, r_neg, r_err;
    logic [BCD_W-1:0]  r_result;
    logic [6:0]        w_a, w_b;
    logic              w_bad, w_fault, w_step_done, w_ge_ab, w_conv_load, w_conv_done;
    logic [DATA_W-1:0] w_mul_nx, w_div_res, w_res;
    logic [BCD_W-1:0]  w_bcd;
`ifdef CALC_SEQ_DIV_EN
    logic [6:0]        r_rem;
    logic [7:0]        w_sh;
    logic              w_ge;
`endif

    always_comb begin
        w_a         = {r_at, 3'b000} + {2'b00, r_at, 1'b0} + {3'b000, r_ao};
        w_b         = {r_bt, 3'b000} + {2'b00, r_bt, 1'b0} + {3'b000, r_bo};
        w_bad       = r_at > 4'd9 || r_ao > 4'd9 || r_bt > 4'd9 || r_bo > 4'd9;
        w_ge_ab     = r_a >= r_b;
        w_mul_nx    = r_acc + (r_b[0] ? DATA_W'(r_a) << r_cnt : '0);
`ifdef CALC_SEQ_DIV_EN
        w_sh        = {r_rem, r_a[6]};
        w_ge        = w_sh >= {1'b0, r_b};
        w_div_res   = DATA_W'({r_a[5:0], w_ge});
        w_fault     = r_op == OP_DIV && r_b == 7'd0;
`else
        w_div_res   = '0;
        w_fault     = r_op == OP_DIV;
`endif
        w_res       = r_op == OP_ADD ? DATA_W'(r_a) + DATA_W'(r_b)
                    : r_op == OP_SUB ? DATA_W'(w_ge_ab ? r_a - r_b : r_b - r_a)
                    : r_op == OP_MUL ? w_mul_nx : w_div_res;
        w_step_done = r_op == OP_ADD || r_op == OP_SUB || r_cnt == 3'd6;
        w_conv_load = r_state == S_EXEC && !w_fault && w_step_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = w_bad ? S_DONE : S_EXEC;
            S_EXEC:  w_next = w_fault ? S_DONE : (w_step_done ? S_CONV : S_EXEC);
            S_CONV:  w_next = w_conv_done ? S_DONE : S_CONV;
            default: w_next = S_IDLE;
        endcase
        busy = r_state == S_LOAD || r_state == S_EXEC || r_state == S_CONV;
        done = r_state == S_DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_ADD;
            {r_at, r_ao, r_bt, r_bo} <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_neg_nx <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
`ifdef CALC_SEQ_DIV_EN
            r_rem    <= '0;
`endif
        end else begin
            if (r_state == S_IDLE && start) begin
                r_op  <= op_t'(op);
                {r_at, r_ao, r_bt, r_bo} <= {a_tens, a_ones, b_tens, b_ones};
                r_err <= 1'b0;
                r_neg <= 1'b0;
            end
            if (r_state == S_LOAD) begin
                r_a      <= w_a;
                r_b      <= w_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_neg_nx <= 1'b0;
`ifdef CALC_SEQ_DIV_EN
                r_rem    <= '0;
`endif
                if (w_bad) begin
                    r_err    <= 1'b1;
                    r_result <= '0;
                end
            end
            if (r_state == S_EXEC) begin
                r_cnt    <= r_cnt + 3'd1;
                r_neg_nx <= r_op == OP_SUB && !w_ge_ab;
                // multiplier bits are consumed LSB-first by shifting b down
                if (r_op == OP_MUL) begin
                    r_acc <= w_mul_nx;
                    r_b   <= r_b >> 1;
                end
`ifdef CALC_SEQ_DIV_EN
                if (r_op == OP_DIV) begin
                    r_a   <= {r_a[5:0], w_ge};
                    r_rem <= 7'(w_ge ? w_sh - {1'b0, r_b} : w_sh);
                end
`endif
                if (w_fault) begin
                    r_err    <= 1'b1;
                    r_result <= '0;
                end
            end
            if (r_state == S_CONV && w_conv_done) begin
                r_result <= w_bcd;
                r_neg    <= r_neg_nx;
            end
        end
    end

    bin2bcd_seq u_b2b (
        .clk  (clk),
        .rst  (rst),
        .load (w_conv_load),
        .bin  (w_res),
        .done (w_conv_done),
        .bcd  (w_bcd)
    );

    assign result_bcd = r_result;
    assign neg        = r_neg;
    assign err        = r_err;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed vectors with a scoreboard queue checked by an independent done monitor
module tb_calc_sequencer;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  a_tens, a_ones, b_tens, b_ones;
    logic [1:0]  op;
    logic        busy, done, neg, err;
    logic [15:0] result_bcd;

    typedef struct {
        logic [15:0] res;
        logic        n;
        logic        e;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

    calc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_tens     (a_tens),
        .a_ones     (a_ones),
        .b_tens     (b_tens),
        .b_ones     (b_ones),
        .op         (op),
        .busy       (busy),
        .done       (done),
        .result_bcd (result_bcd),
        .neg        (neg),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result_bcd", 32'(result_bcd), 32'(e.res));
                check("neg", 32'(neg), 32'(e.n));
                check("err", 32'(err), 32'(e.e));
                check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic go(input logic [3:0] at, input logic [3:0] ao, input logic [3:0] bt, input logic [3:0] bo,
                      input logic [1:0] o, input logic [15:0] res, input logic n, input logic e,
                      input int lat, input bit push);
        exp_t x;
        @(negedge clk);
        {a_tens, a_ones, b_tens, b_ones, op} = {at, ao, bt, bo, o};
        start = 1'b1;
        x.res = res; x.n = n; x.e = e; x.lat = lat; x.t0 = cyc;
        if (push) q.push_back(x);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("clear_on_start", 32'({neg, err}), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected done", n);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        {a_tens, a_ones, b_tens, b_ones, op} = '0;
        #1;
        check("reset_outputs", 32'({busy, done, neg, err, result_bcd}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        go(4'd1, 4'd2, 4'd3, 4'd4, ADD, 16'h0046, 1'b0, 1'b0, 17, 1'b1); wait_done();
        go(4'd0, 4'd5, 4'd7, 4'd2, SUB, 16'h0067, 1'b1, 1'b0, 17, 1'b1); wait_done();
        go(4'd7, 4'd2, 4'd0, 4'd5, SUB, 16'h0067, 1'b0, 1'b0, 17, 1'b1); wait_done();
        go(4'd3, 4'd3, 4'd3, 4'd3, SUB, 16'h0000, 1'b0, 1'b0, 17, 1'b1); wait_done();
        go(4'd9, 4'd9, 4'd9, 4'd9, ADD, 16'h0198, 1'b0, 1'b0, 17, 1'b1); wait_done();
        go(4'd1, 4'd3, 4'd0, 4'd7, MUL, 16'h0091, 1'b0, 1'b0, 23, 1'b1); wait_done();
        go(4'd8, 4'd7, 4'd0, 4'd0, DIV, 16'h0000, 1'b0, 1'b1, 3, 1'b1); wait_done();
        go(4'd0, 4'd0, 4'd5, 4'd7, MUL, 16'h0000, 1'b0, 1'b0, 23, 1'b1); wait_done();
        go(4'd6, 4'd1, 4'd2, 4'd0, ADD, 16'h0081, 1'b0, 1'b0, 17, 1'b1); wait_done();
        go(4'd1, 4'hA, 4'd0, 4'd1, ADD, 16'h0000, 1'b0, 1'b1, 2, 1'b1); wait_done();
        go(4'd2, 4'd2, 4'hF, 4'd0, SUB, 16'h0000, 1'b0, 1'b1, 2, 1'b1); wait_done();
`ifdef CALC_SEQ_DIV_EN
        go(4'd8, 4'd7, 4'd0, 4'd4, DIV, 16'h0021, 1'b0, 1'b0, 23, 1'b1); wait_done();
        go(4'd5, 4'd0, 4'd0, 4'd7, DIV, 16'h0007, 1'b0, 1'b0, 23, 1'b1); wait_done();
        go(4'd9, 4'd9, 4'd9, 4'd9, DIV, 16'h0001, 1'b0, 1'b0, 23, 1'b1); wait_done();
`else
        go(4'd8, 4'd7, 4'd0, 4'd4, DIV, 16'h0000, 1'b0, 1'b1, 3, 1'b1); wait_done();
`endif

        // start pulsed while busy must not disturb the running multiply
        go(4'd9, 4'd9, 4'd9, 4'd9, MUL, 16'h9801, 1'b0, 1'b0, 23, 1'b1);
        repeat (4) @(negedge clk);
        {a_tens, a_ones, b_tens, b_ones, op} = {4'd1, 4'd1, 4'd1, 4'd1, ADD};
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done();

        // start pulsed in DONE must be ignored
        {a_tens, a_ones, b_tens, b_ones, op} = {4'd2, 4'd2, 4'd2, 4'd2, ADD};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", 32'(busy), 32'd0);
        check("result_hold", 32'(result_bcd), 32'h9801);

        // asynchronous reset in the middle of conversion
        go(4'd1, 4'd2, 4'd3, 4'd4, ADD, 16'h0046, 1'b0, 1'b0, 17, 1'b0);
        repeat (8) @(negedge clk);
        check("busy_mid_conv", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({busy, done, neg, err, result_bcd}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        go(4'd4, 4'd5, 4'd0, 4'd6, ADD, 16'h0051, 1'b0, 1'b0, 17, 1'b1); wait_done();

        repeat (5) @(negedge clk);
        check("all_done_seen", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of run by 100000 ns, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
